rfphoenix_issue_scoreboard: RTL and testbench

Issue controller between the rfPhoenix decode stage and the execute/memory units. It holds per-register pending-write scoreboards for the scalar and vector register files. It stalls a decoded instruction on RAW or WAW hazards against in-flight multicycle operations and caps outstanding memory operations. It also sequences pipeline drains for flushes and serializing (CSR) instructions.

---
 rtl/rfphoenix_issue_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_rfphoenix_issue_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_issue_scoreboard.sv
// rfPhoenix issue scoreboard: tracks pending multicycle writes to the scalar
// and vector register files, stalls RAW/WAW hazards, caps outstanding memory
// operations and sequences drains for flushes and serializing instructions.
module rfphoenix_issue_scoreboard #(
    parameter int NREGS  = 64,
    parameter int MAXMEM = 4,
    parameter int RZ     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dec_valid_i,
    output logic                     dec_ready_o,
    output logic                     issue_o,
    input  logic [$clog2(NREGS)-1:0] ra_i,
    input  logic [$clog2(NREGS)-1:0] rb_i,
    input  logic [$clog2(NREGS)-1:0] rc_i,
    input  logic                     ta_i,
    input  logic                     tb_i,
    input  logic                     tc_i,
    input  logic [$clog2(NREGS)-1:0] rt_i,
    input  logic                     rfwr_i,
    input  logic                     vrfwr_i,
    input  logic                     multicycle_i,
    input  logic                     mem_i,
    input  logic                     serial_i,
    input  logic                     wb_valid_i,
    input  logic [$clog2(NREGS)-1:0] wb_rt_i,
    input  logic                     wb_vec_i,
    input  logic                     mem_done_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic [2:0]               memcnt_o
);

    localparam int IW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_QUIET = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NREGS-1:0] sb_s_q, sb_s_d;
    logic [NREGS-1:0] sb_v_q, sb_v_d;
    logic [2:0]       memcnt_q, memcnt_d;

    logic [NREGS-1:0] wb_clr_s, wb_clr_v;
    logic [NREGS-1:0] set_s, set_v;
    logic [NREGS-1:0] eff_s, eff_v;
    logic             wb_en;
    logic             src_a, src_b, src_c;
    logic             raw, waw, mem_stall, quiet;
    logic             ready, issue;
    logic             mem_inc, mem_dec;

    // Writebacks are meaningless while draining: the boards were just wiped.
    assign wb_en = wb_valid_i & (state_q != ST_DRAIN);

    // Per-register decode of writeback clears and issue sets.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            localparam logic [IW-1:0] IDX = IW'(gi);
            assign wb_clr_s[gi] = wb_en & ~wb_vec_i & (wb_rt_i == IDX);
            assign wb_clr_v[gi] = wb_en &  wb_vec_i & (wb_rt_i == IDX);
            assign set_v[gi]    = issue & multicycle_i & vrfwr_i & (rt_i == IDX);
            if (RZ != 0 && gi == 0) begin : g_zero
                // Hard-zero r0 is never pending, so it can never cause a hazard.
                assign set_s[gi] = 1'b0;
            end else begin : g_reg
                assign set_s[gi] = issue & multicycle_i & rfwr_i & (rt_i == IDX);
            end
        end
    endgenerate

    // A same-cycle writeback is forwarded: its bit no longer counts as pending.
    assign eff_s = sb_s_q & ~wb_clr_s;
    assign eff_v = sb_v_q & ~wb_clr_v;

    assign src_a = ta_i ? eff_v[ra_i] : eff_s[ra_i];
    assign src_b = tb_i ? eff_v[rb_i] : eff_s[rb_i];
    assign src_c = tc_i ? eff_v[rc_i] : eff_s[rc_i];

    assign raw       = src_a | src_b | src_c;
    assign waw       = (rfwr_i & eff_s[rt_i]) | (vrfwr_i & eff_v[rt_i]);
    // A completion in the same cycle frees a slot for the new memory op.
    assign mem_stall = mem_i & (memcnt_q == 3'(MAXMEM)) & ~mem_done_i;
    assign quiet     = (sb_s_q == '0) & (sb_v_q == '0) & (memcnt_q == 3'd0);

    // Issue permission; a flush or held reset blocks issue outright.
    always_comb begin
        ready = 1'b0;
        if (rst_ni && !flush_i) begin
            case (state_q)
                ST_RUN:   ready = ~(raw | waw | mem_stall) & ~serial_i;
                ST_QUIET: ready = quiet;
                default:  ready = 1'b0;
            endcase
        end
    end

    assign issue       = dec_valid_i & ready;
    assign dec_ready_o = ready;
    assign issue_o     = issue;

    // Outstanding memory count; a done with nothing outstanding is ignored.
    assign mem_inc = issue & mem_i;
    assign mem_dec = mem_done_i & (memcnt_q != 3'd0);

    always_comb begin
        memcnt_d = memcnt_q;
        if (mem_inc && !mem_dec) begin
            memcnt_d = memcnt_q + 3'd1;
        end else if (!mem_inc && mem_dec) begin
            memcnt_d = memcnt_q - 3'd1;
        end
    end

    // Scoreboard next state: flush wipes, drain holds, otherwise clear then set.
    always_comb begin
        sb_s_d = (sb_s_q & ~wb_clr_s) | set_s;
        sb_v_d = (sb_v_q & ~wb_clr_v) | set_v;
        if (flush_i) begin
            sb_s_d = '0;
            sb_v_d = '0;
        end else if (state_q == ST_DRAIN) begin
            sb_s_d = sb_s_q;
            sb_v_d = sb_v_q;
        end
    end

    // Issue sequencing: serializing instructions wait for quiet, flushes drain memory.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_RUN:   if (dec_valid_i && serial_i) state_d = ST_QUIET;
                ST_QUIET: if (quiet) state_d = ST_RUN;
                ST_DRAIN: if (memcnt_d == 3'd0) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    assign busy_o   = (state_q != ST_RUN) | (|sb_s_q) | (|sb_v_q) | (memcnt_q != 3'd0);
    assign memcnt_o = memcnt_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            sb_s_q   <= '0;
            sb_v_q   <= '0;
            memcnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sb_s_q   <= sb_s_d;
            sb_v_q   <= sb_v_d;
            memcnt_q <= memcnt_d;
        end
    end

endmodule

// File: tb/tb_rfphoenix_issue_scoreboard.sv
// Directed bench for rfphoenix_issue_scoreboard with hand-computed expectations.
module tb_rfphoenix_issue_scoreboard;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       dec_valid_i;
    logic       dec_ready_o;
    logic       issue_o;
    logic [5:0] ra_i, rb_i, rc_i, rt_i, wb_rt_i;
    logic       ta_i, tb_i, tc_i;
    logic       rfwr_i, vrfwr_i, multicycle_i, mem_i, serial_i;
    logic       wb_valid_i, wb_vec_i, mem_done_i, flush_i;
    logic       busy_o;
    logic [2:0] memcnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    rfphoenix_issue_scoreboard #(
        .NREGS (64),
        .MAXMEM(4),
        .RZ    (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .issue_o     (issue_o),
        .ra_i        (ra_i),
        .rb_i        (rb_i),
        .rc_i        (rc_i),
        .ta_i        (ta_i),
        .tb_i        (tb_i),
        .tc_i        (tc_i),
        .rt_i        (rt_i),
        .rfwr_i      (rfwr_i),
        .vrfwr_i     (vrfwr_i),
        .multicycle_i(multicycle_i),
        .mem_i       (mem_i),
        .serial_i    (serial_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rt_i     (wb_rt_i),
        .wb_vec_i    (wb_vec_i),
        .mem_done_i  (mem_done_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .memcnt_o    (memcnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen here.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dec_valid_i = 0; ra_i = 0; rb_i = 0; rc_i = 0; rt_i = 0;
        ta_i = 0; tb_i = 0; tc_i = 0;
        rfwr_i = 0; vrfwr_i = 0; multicycle_i = 0; mem_i = 0; serial_i = 0;
        wb_valid_i = 0; wb_rt_i = 0; wb_vec_i = 0; mem_done_i = 0; flush_i = 0;
    endtask

    initial begin
        idle();
        rst_ni = 0;
        dec_valid_i = 1;
        cyc(); cyc();
        chk("rst_ready", dec_ready_o, 0);
        chk("rst_issue", issue_o, 0);
        rst_ni = 1; idle();
        cyc(); #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_memcnt", memcnt_o, 0);

        // Multicycle scalar write r5, then dependent ADD reads r5.
        dec_valid_i = 1; rt_i = 5; rfwr_i = 1; multicycle_i = 1; #1;
        chk("fma_issue", issue_o, 1);
        cyc(); idle();
        dec_valid_i = 1; ra_i = 5; rt_i = 6; rfwr_i = 1; #1;
        chk("raw_stall1", dec_ready_o, 0);
        cyc(); #1;
        chk("raw_stall2", dec_ready_o, 0);
        wb_valid_i = 1; wb_rt_i = 5; #1;
        chk("raw_fwd_issue", issue_o, 1);
        cyc(); idle(); #1;
        chk("raw_busy_clr", busy_o, 0);

        // Scalar/vector separation on register 5.
        dec_valid_i = 1; rt_i = 5; vrfwr_i = 1; multicycle_i = 1; #1;
        chk("vfma_issue", issue_o, 1);
        cyc(); idle();
        dec_valid_i = 1; ra_i = 5; ta_i = 0; #1;
        chk("sep_scalar_ok", issue_o, 1);
        ta_i = 1; #1;
        chk("sep_vector_stall", dec_ready_o, 0);
        ta_i = 0; rb_i = 5; tb_i = 1; #1;
        chk("sep_srcb_stall", dec_ready_o, 0);
        idle(); dec_valid_i = 1; rt_i = 5; vrfwr_i = 1; #1;
        chk("waw_stall", dec_ready_o, 0);
        idle(); wb_valid_i = 1; wb_rt_i = 5; wb_vec_i = 0;
        cyc(); idle(); #1;
        chk("wrong_file_wb", busy_o, 1);
        wb_valid_i = 1; wb_rt_i = 5; wb_vec_i = 1;
        cyc(); idle(); #1;
        chk("vwb_busy_clr", busy_o, 0);

        // Memory cap.
        dec_valid_i = 1; mem_i = 1;
        cyc(); cyc(); cyc(); cyc(); #1;
        chk("mem_cnt4", memcnt_o, 4);
        chk("mem_5th_stall", dec_ready_o, 0);
        mem_done_i = 1; #1;
        chk("mem_5th_fwd", issue_o, 1);
        cyc(); idle(); #1;
        chk("mem_cnt_stays4", memcnt_o, 4);
        mem_done_i = 1;
        cyc(); cyc(); cyc(); cyc();
        cyc(); idle(); #1;
        chk("mem_spurious_done", memcnt_o, 0);

        // Serialization: r3 pending and one memory op outstanding.
        dec_valid_i = 1; rt_i = 3; rfwr_i = 1; multicycle_i = 1; mem_i = 1;
        cyc(); idle();
        dec_valid_i = 1; serial_i = 1; #1;
        chk("ser_run_stall", dec_ready_o, 0);
        cyc(); #1;
        chk("ser_quiet_stall", dec_ready_o, 0);
        chk("ser_quiet_busy", busy_o, 1);
        wb_valid_i = 1; wb_rt_i = 3; mem_done_i = 1; #1;
        chk("ser_wb_cycle", dec_ready_o, 0);
        cyc(); wb_valid_i = 0; mem_done_i = 0; #1;
        chk("ser_issue", issue_o, 1);
        cyc(); idle(); #1;
        chk("ser_back_run", busy_o, 0);
        dec_valid_i = 1; ra_i = 3; #1;
        chk("ser_after_ready", dec_ready_o, 1);

        // Flush with two memory ops and v7 pending.
        idle(); dec_valid_i = 1; mem_i = 1;
        cyc(); rt_i = 7; vrfwr_i = 1; multicycle_i = 1;
        cyc(); idle(); #1;
        chk("fl_memcnt2", memcnt_o, 2);
        dec_valid_i = 1; rt_i = 9; rfwr_i = 1; multicycle_i = 1; flush_i = 1; #1;
        chk("fl_no_issue", issue_o, 0);
        cyc(); idle();
        dec_valid_i = 1; wb_valid_i = 1; wb_rt_i = 9; #1;
        chk("fl_drain_ready", dec_ready_o, 0);
        chk("fl_drain_busy", busy_o, 1);
        wb_valid_i = 0; mem_done_i = 1; #1;
        chk("fl_done1_ready", dec_ready_o, 0);
        cyc(); #1;
        chk("fl_done2_ready", dec_ready_o, 0);
        cyc(); idle(); #1;
        chk("fl_run_busy", busy_o, 0);
        dec_valid_i = 1; ra_i = 7; ta_i = 1; rb_i = 9; #1;
        chk("fl_boards_clear", issue_o, 1);

        // Flush with nothing outstanding drains for exactly one cycle.
        idle(); flush_i = 1;
        cyc(); idle(); #1;
        chk("fl0_drain", busy_o, 1);
        cyc(); #1;
        chk("fl0_run", busy_o, 0);

        // r0 is hard zero.
        dec_valid_i = 1; rt_i = 0; rfwr_i = 1; multicycle_i = 1; #1;
        chk("r0_issue", issue_o, 1);
        cyc(); idle(); #1;
        chk("r0_not_pending", busy_o, 0);
        dec_valid_i = 1; ra_i = 0; rb_i = 0; rc_i = 0; #1;
        chk("r0_read", dec_ready_o, 1);

        // Reset in the middle of QUIET.
        idle(); dec_valid_i = 1; rt_i = 4; rfwr_i = 1; multicycle_i = 1;
        cyc(); idle(); dec_valid_i = 1; serial_i = 1;
        cyc(); #1;
        chk("rq_quiet_stall", dec_ready_o, 0);
        rst_ni = 0;
        cyc(); rst_ni = 1; idle(); #1;
        chk("rq_busy", busy_o, 0);
        dec_valid_i = 1; ra_i = 4; #1;
        chk("rq_r4_clear", issue_o, 1);
        cyc(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
